// File: rtl/i2c_bit_master_if.sv
// rtl/i2c_bit_master_if.sv - command/response and pad bundle for the I2C bit-level initiator
//
// Purpose: groups the byte-command handshake, the response, and the open-drain
// pad signals of i2c_bit_master into one bundle.
// Signals:
//   cmd_valid/cmd_ready/cmd/wr_data   command request and handshake
//   rsp_valid/rsp_status/rd_data      one-cycle completion and result
//   bus_held                          bus owned between START and STOP
//   scl_i/sda_i                       sampled pad levels
//   scl_oe/sda_oe                     1 pulls the line low, 0 releases it
// Modports: slave = the initiator block, master = the command layer driving it.

interface i2c_bit_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd;
   logic [7:0] wr_data;
   logic       rsp_valid;
   logic [1:0] rsp_status;
   logic [7:0] rd_data;
   logic       bus_held;
   logic       scl_i;
   logic       sda_i;
   logic       scl_oe;
   logic       sda_oe;

   modport slave (
      input  cmd_valid, cmd, wr_data, scl_i, sda_i,
      output cmd_ready, rsp_valid, rsp_status, rd_data, bus_held, scl_oe, sda_oe
   );

   modport master (
      output cmd_valid, cmd, wr_data, scl_i, sda_i,
      input  cmd_ready, rsp_valid, rsp_status, rd_data, bus_held, scl_oe, sda_oe
   );
endinterface

// File: rtl/i2c_bit_master.sv
// rtl/i2c_bit_master.sv - byte-command I2C initiator driving open-drain SCL/SDA
//
// Purpose: turns START / STOP / WRITE / READ_ACK / READ_NACK commands into
// SCL/SDA waveforms. Every bit is four quarters Q0..Q3 of QTR_CYCLES clocks:
// SCL low in Q0-Q1, released in Q2-Q3; SDA changes at the start of Q0 and is
// sampled on the last cycle of Q2.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; releases both lines at once
//   bus    i2c_bit_master_if.slave (command, response, pad signals)
// Optional feature macro: I2C_CLK_STRETCH_EN - when defined, the quarter
// counter stalls in Q2 while scl_i is still low after SCL was released.

module i2c_bit_master #(
   parameter int QTR_CYCLES = 250,
   parameter int DATA_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   i2c_bit_master_if.slave  bus
);

   localparam int            QW   = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
   localparam logic [QW-1:0] QMAX = QW'(QTR_CYCLES - 1);
   localparam int            BW   = $clog2(DATA_W);
   localparam logic [BW-1:0] BMAX = BW'(DATA_W - 1);

   localparam logic [1:0] ST_OK  = 2'd0;
   localparam logic [1:0] ST_NAK = 2'd1;
   localparam logic [1:0] ST_ARB = 2'd2;
   localparam logic [1:0] ST_ERR = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_WBIT, S_WACK, S_RBIT, S_RACK, S_STOP, S_RSP
   } state_t;

   state_t            r_state;
   logic [QW-1:0]     r_qcnt;
   logic [1:0]        r_phase;
   logic [BW-1:0]     r_bit;
   logic [DATA_W-1:0] r_shift;
   logic [7:0]        r_rd_data;
   logic              r_nak;
   logic              r_rd_ack;
   logic              r_bus_held;
   logic [1:0]        r_status;
   logic              r_cmd_ready;

   state_t            w_state_nxt;
   logic [1:0]        w_status_nxt;
   logic              w_held_nxt;
   logic              w_accept;
   logic              w_busy;
   logic              w_hold;
   logic              w_qlast;
   logic              w_sample;
   logic              w_bit_end;
   logic              w_arb;
   logic              w_scl_oe;
   logic              w_sda_oe;
   logic              w_rsp_valid;

   assign w_accept = bus.cmd_valid && r_cmd_ready;
   assign w_busy   = (r_state != S_IDLE) && (r_state != S_RSP);

`ifdef I2C_CLK_STRETCH_EN
   // A responder holding SCL low after release freezes the bit timing,
   // which also delays the Q2 sample point.
   assign w_hold = w_busy && (r_phase == 2'd2) && !bus.scl_i;
`else
   assign w_hold = 1'b0;
`endif

   assign w_qlast   = w_busy && (r_qcnt == QMAX) && !w_hold;
   assign w_sample  = w_qlast && (r_phase == 2'd2);
   assign w_bit_end = w_qlast && (r_phase == 2'd3);

   // Lost arbitration: we released SDA (START Q0-Q2 or a '1' data bit) but
   // another initiator holds it low while SCL is high.
   assign w_arb = w_sample && !bus.sda_i &&
                  ((r_state == S_START) || ((r_state == S_WBIT) && r_shift[DATA_W-1]));

   // State register and datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_qcnt      <= '0;
         r_phase     <= 2'd0;
         r_bit       <= '0;
         r_shift     <= '0;
         r_rd_data   <= 8'd0;
         r_nak       <= 1'b0;
         r_rd_ack    <= 1'b0;
         r_bus_held  <= 1'b0;
         r_status    <= ST_OK;
         r_cmd_ready <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_status    <= w_status_nxt;
         r_bus_held  <= w_held_nxt;
         // Registered from the next state so the handshake stays low in reset.
         r_cmd_ready <= (w_state_nxt == S_IDLE);

         if (!w_busy) begin
            r_qcnt  <= '0;
            r_phase <= 2'd0;
         end else if (!w_hold) begin
            if (r_qcnt == QMAX) begin
               r_qcnt  <= '0;
               r_phase <= r_phase + 2'd1;
            end else begin
               r_qcnt <= r_qcnt + QW'(1);
            end
         end

         if (w_accept) begin
            r_shift  <= bus.wr_data;
            r_bit    <= '0;
            r_rd_ack <= (bus.cmd == 3'd3);
         end

         case (r_state)
            S_WBIT: begin
               if (w_bit_end) begin
                  r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                  r_bit   <= r_bit + BW'(1);
               end
            end
            S_WACK: begin
               if (w_sample) r_nak <= bus.sda_i;
            end
            S_RBIT: begin
               if (w_sample)  r_shift <= {r_shift[DATA_W-2:0], bus.sda_i};
               if (w_bit_end) r_bit   <= r_bit + BW'(1);
            end
            S_RACK: begin
               if (w_bit_end) r_rd_data <= r_shift;
            end
            default: ;
         endcase
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt  = r_state;
      w_status_nxt = r_status;
      w_held_nxt   = r_bus_held;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt  = S_RSP;
               w_status_nxt = ST_ERR;
               case (bus.cmd)
                  3'd0: w_state_nxt = S_START;
                  3'd1: if (r_bus_held) w_state_nxt = S_STOP;
                  3'd2: if (r_bus_held) w_state_nxt = S_WBIT;
                  3'd3,
                  3'd4: if (r_bus_held) w_state_nxt = S_RBIT;
                  default: ;
               endcase
            end
         end
         S_START: begin
            if (w_arb) begin
               w_state_nxt  = S_RSP;
               w_status_nxt = ST_ARB;
               w_held_nxt   = 1'b0;
            end else if (w_bit_end) begin
               w_state_nxt  = S_RSP;
               w_status_nxt = ST_OK;
               w_held_nxt   = 1'b1;
            end
         end
         S_WBIT: begin
            if (w_arb) begin
               w_state_nxt  = S_RSP;
               w_status_nxt = ST_ARB;
               w_held_nxt   = 1'b0;
            end else if (w_bit_end && (r_bit == BMAX)) begin
               w_state_nxt = S_WACK;
            end
         end
         S_WACK: begin
            if (w_bit_end) begin
               w_state_nxt  = S_RSP;
               w_status_nxt = r_nak ? ST_NAK : ST_OK;
            end
         end
         S_RBIT: begin
            if (w_bit_end && (r_bit == BMAX)) w_state_nxt = S_RACK;
         end
         S_RACK: begin
            if (w_bit_end) begin
               w_state_nxt  = S_RSP;
               w_status_nxt = ST_OK;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_state_nxt  = S_RSP;
               w_status_nxt = ST_OK;
               w_held_nxt   = 1'b0;
            end
         end
         S_RSP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic. Between commands SCL stays low while the bus is owned so
   // the responder cannot see a spurious START/STOP.
   always_comb begin
      w_scl_oe    = 1'b0;
      w_sda_oe    = 1'b0;
      w_rsp_valid = 1'b0;
      case (r_state)
         S_IDLE:  w_scl_oe = r_bus_held;
         S_RSP: begin
            w_scl_oe    = r_bus_held;
            w_rsp_valid = 1'b1;
         end
         S_START: begin
            w_scl_oe = r_bus_held && (r_phase < 2'd2);
            w_sda_oe = (r_phase == 2'd3);
         end
         S_WBIT: begin
            w_scl_oe = (r_phase < 2'd2);
            w_sda_oe = !r_shift[DATA_W-1];
         end
         S_WACK,
         S_RBIT:  w_scl_oe = (r_phase < 2'd2);
         S_RACK: begin
            w_scl_oe = (r_phase < 2'd2);
            w_sda_oe = r_rd_ack;
         end
         S_STOP: begin
            w_scl_oe = (r_phase < 2'd2);
            w_sda_oe = (r_phase != 2'd3);
         end
         default: ;
      endcase
   end

   assign bus.cmd_ready  = r_cmd_ready;
   assign bus.rsp_valid  = w_rsp_valid;
   assign bus.rsp_status = r_status;
   assign bus.rd_data    = r_rd_data;
   assign bus.bus_held   = r_bus_held;
   assign bus.scl_oe     = w_scl_oe;
   assign bus.sda_oe     = w_sda_oe;

endmodule

// File: tb/tb_i2c_bit_master.sv
// tb/tb_i2c_bit_master.sv - scoreboard bench for i2c_bit_master with a simple responder

module tb_i2c_bit_master;
   localparam int Q = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   i2c_bit_master_if bus();

   i2c_bit_master #(.QTR_CYCLES(Q), .DATA_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Open-drain pad model
   logic force_low   = 1'b0;
   logic stretch_low = 1'b0;
   logic resp_pull;
   assign bus.scl_i = !(bus.scl_oe || stretch_low);
   assign bus.sda_i = !(bus.sda_oe || resp_pull || force_low);

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_rsp = 0;
   int   n_exp = 0;

   // Bus observers, sampled once per clock so simultaneous SCL/SDA changes
   // are not mistaken for START/STOP.
   int   fall_cnt = 0, rise_cnt = 0, start_cnt = 0, stop_cnt = 0;
   int   scl_edges = 0, sda_edges = 0;
   logic prev_scl = 1'b1, prev_sda = 1'b1;
   logic rise_bits [0:1023];
   int   fbase = 0, rbase = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      prev_scl <= bus.scl_i;
      prev_sda <= bus.sda_i;
      if (prev_scl !== bus.scl_i) scl_edges <= scl_edges + 1;
      if (prev_sda !== bus.sda_i) sda_edges <= sda_edges + 1;
      if (prev_scl === 1'b1 && bus.scl_i === 1'b0) fall_cnt <= fall_cnt + 1;
      if (prev_scl === 1'b0 && bus.scl_i === 1'b1) begin
         rise_bits[rise_cnt % 1024] <= bus.sda_i;
         rise_cnt <= rise_cnt + 1;
      end
      if (prev_scl === 1'b1 && bus.scl_i === 1'b1) begin
         if (prev_sda === 1'b1 && bus.sda_i === 1'b0) start_cnt <= start_cnt + 1;
         if (prev_sda === 1'b0 && bus.sda_i === 1'b1) stop_cnt  <= stop_cnt + 1;
      end
   end

   // Responder: 0 silent, 1 ACK a write, 2 NACK a write, 3 send resp_byte
   int         resp_mode = 0;
   logic [7:0] resp_byte = 8'h00;
   always_comb begin
      int c;
      resp_pull = 1'b0;
      c = fall_cnt - fbase;
      case (resp_mode)
         1: resp_pull = (c == 8);
         3: if (c >= 0 && c < 8) resp_pull = !resp_byte[7 - c];
         default: ;
      endcase
   end

   typedef struct {
      logic [1:0] status;
      logic [7:0] rd;
      bit         chk_rd;
      logic       held;
      int         lat;
      int         acc;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: pops the expectation for every response pulse
   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_status", bus.rsp_status, e.status);
            check("rsp_bus_held", bus.bus_held, e.held);
            check("rsp_latency", cyc + 1 - e.acc, e.lat);
            if (e.chk_rd) check("rsp_rd_data", bus.rd_data, e.rd);
         end
         n_rsp <= n_rsp + 1;
      end
   end

   task automatic issue(input logic [2:0] c, input logic [7:0] d, input logic [1:0] st,
                        input logic [7:0] rd, input bit chk_rd, input logic held,
                        input int lat, input bit push);
      exp_t e;
      bit   ok = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (bus.cmd_ready === 1'b1) begin ok = 1; break; end
      end
      if (!ok) check("cmd_ready_timeout", 32'd0, 32'd1);
      bus.cmd       = c;
      bus.wr_data   = d;
      bus.cmd_valid = 1'b1;
      fbase = fall_cnt;
      rbase = rise_cnt;
      if (push) begin
         e.status = st; e.rd = rd; e.chk_rd = chk_rd; e.held = held;
         e.lat = lat; e.acc = cyc + 1;
         exp_q.push_back(e);
         n_exp++;
      end
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      bit ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #1;
         if (n_rsp >= n_exp) begin ok = 1; break; end
      end
      if (!ok) check("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"},  bus.cmd_ready,  1'b0);
      check({tag, "_rsp_valid"},  bus.rsp_valid,  1'b0);
      check({tag, "_rsp_status"}, bus.rsp_status, 2'd0);
      check({tag, "_rd_data"},    bus.rd_data,    8'h00);
      check({tag, "_bus_held"},   bus.bus_held,   1'b0);
      check({tag, "_scl_oe"},     bus.scl_oe,     1'b0);
      check({tag, "_sda_oe"},     bus.sda_oe,     1'b0);
   endtask

   localparam logic [1:0] OK = 2'd0, NAK = 2'd1, ARB = 2'd2, ERR = 2'd3;

   initial begin
      int         s_start, s_stop, e_scl, e_sda;
      logic [7:0] b;
      bus.cmd_valid = 1'b0;
      bus.cmd       = 3'd0;
      bus.wr_data   = 8'h00;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // 1: START, WRITE 0x44 acked
      s_start = start_cnt;
      issue(3'd0, 8'h00, OK, 8'h00, 0, 1'b1, 4*Q + 1, 1);
      wait_rsp();
      check("t1_start_seen", start_cnt - s_start, 32'd1);
      resp_mode = 1;
      issue(3'd2, 8'h44, OK, 8'h00, 0, 1'b1, 36*Q + 1, 1);
      wait_rsp();
      resp_mode = 0;
      b = 8'h44;
      for (int i = 0; i < 8; i++) check($sformatf("t1_bit%0d", i), rise_bits[rbase + i], b[7 - i]);
      check("t1_ack_bit", rise_bits[rbase + 8], 1'b0);

      // 2: WRITE 0x45, READ_NACK of 0xA5, STOP
      resp_mode = 1;
      issue(3'd2, 8'h45, OK, 8'h00, 0, 1'b1, 36*Q + 1, 1);
      wait_rsp();
      resp_mode = 3;
      resp_byte = 8'hA5;
      issue(3'd4, 8'h00, OK, 8'hA5, 1, 1'b1, 36*Q + 1, 1);
      wait_rsp();
      resp_mode = 0;
      check("t2_nack_released", rise_bits[rbase + 8], 1'b1);
      s_stop = stop_cnt;
      issue(3'd1, 8'h00, OK, 8'h00, 0, 1'b0, 4*Q + 1, 1);
      wait_rsp();
      check("t2_stop_seen", stop_cnt - s_stop, 32'd1);

      // 3: NACKed WRITE 0x10, then repeated START
      issue(3'd0, 8'h00, OK, 8'h00, 0, 1'b1, 4*Q + 1, 1);
      wait_rsp();
      resp_mode = 2;
      issue(3'd2, 8'h10, NAK, 8'h00, 0, 1'b1, 36*Q + 1, 1);
      wait_rsp();
      resp_mode = 0;
      s_start = start_cnt;
      s_stop  = stop_cnt;
      issue(3'd0, 8'h00, OK, 8'h00, 0, 1'b1, 4*Q + 1, 1);
      wait_rsp();
      check("t3_rstart_seen", start_cnt - s_start, 32'd1);
      check("t3_no_stop", stop_cnt - s_stop, 32'd0);
      issue(3'd1, 8'h00, OK, 8'h00, 0, 1'b0, 4*Q + 1, 1);
      wait_rsp();

      // 4: arbitration lost on the first (driven-1) bit of 0x80
      issue(3'd0, 8'h00, OK, 8'h00, 0, 1'b1, 4*Q + 1, 1);
      wait_rsp();
      issue(3'd2, 8'h80, ARB, 8'h00, 0, 1'b0, 3*Q + 1, 1);
      force_low = 1'b1;
      wait_rsp();
      check("t4_scl_oe", bus.scl_oe, 1'b0);
      check("t4_sda_oe", bus.sda_oe, 1'b0);
      check("t4_bus_held", bus.bus_held, 1'b0);
      force_low = 1'b0;
      repeat (2) @(negedge clk);

      // 5: illegal commands on an idle bus
      e_scl = scl_edges;
      e_sda = sda_edges;
      issue(3'd1, 8'h00, ERR, 8'h00, 0, 1'b0, 1, 1);
      wait_rsp();
      issue(3'd6, 8'h00, ERR, 8'h00, 0, 1'b0, 1, 1);
      wait_rsp();
      issue(3'd2, 8'h5A, ERR, 8'h00, 0, 1'b0, 1, 1);
      wait_rsp();
      repeat (2) @(negedge clk);
      check("t5_scl_quiet", scl_edges - e_scl, 32'd0);
      check("t5_sda_quiet", sda_edges - e_sda, 32'd0);

`ifdef I2C_CLK_STRETCH_EN
      // Stretch: responder holds SCL low 20 cycles in Q2 of the first bit
      issue(3'd0, 8'h00, OK, 8'h00, 0, 1'b1, 4*Q + 1, 1);
      wait_rsp();
      resp_mode = 1;
      issue(3'd2, 8'h44, OK, 8'h00, 0, 1'b1, 36*Q + 1 + 20, 1);
      begin
         bit seen = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.scl_oe === 1'b0) begin seen = 1; break; end
         end
         if (!seen) check("stretch_release_timeout", 32'd0, 32'd1);
      end
      stretch_low = 1'b1;
      repeat (20) @(negedge clk);
      stretch_low = 1'b0;
      wait_rsp();
      resp_mode = 0;
      issue(3'd1, 8'h00, OK, 8'h00, 0, 1'b0, 4*Q + 1, 1);
      wait_rsp();
`endif

      // 6: asynchronous reset in the middle of a WRITE
      issue(3'd0, 8'h00, OK, 8'h00, 0, 1'b1, 4*Q + 1, 1);
      wait_rsp();
      resp_mode = 1;
      issue(3'd2, 8'h55, OK, 8'h00, 0, 1'b1, 0, 0);
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("midreset");
      resp_mode = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("end_queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
